// File: rtl/booth_r4_mul_pipe.sv
// Iterative radix-4 Booth multiplier for RV32M/RV64M MUL/MULH/MULHSU/MULHU with valid/ready
// handshakes, a tag travelling with each op, optional early termination and a flush.
module booth_r4_mul_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 4,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mul_type,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned EW = XLEN + 2;
  localparam int unsigned PW = 2 * XLEN + 4;
  localparam int unsigned VW = XLEN + 3;
  localparam int unsigned ND = XLEN / 2 + 1;
  localparam int unsigned CW = $clog2(ND + 1);

  typedef enum logic [1:0] {StIdle, StPre, StCalc, StDone} state_e;

  state_e           state_q;
  logic [EW-1:0]    a_q;
  logic [VW-1:0]    opv_q;
  logic [PW-1:0]    pa_q, p2a_q, na_q, n2a_q, prod_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       type_q;
  logic [TAG_W-1:0] tag_q;

  logic [EW-1:0] ext_a, ext_b;
  logic [PW-1:0] a_wide, sel, addend;
  logic          early, last_digit;

  always_comb begin
    ext_a  = (mul_type == 2'b11) ? {2'b00, op_a} : {{2{op_a[XLEN-1]}}, op_a};
    ext_b  = mul_type[1] ? {2'b00, op_b} : {{2{op_b[XLEN-1]}}, op_b};
    a_wide = {{(PW - EW){a_q[EW-1]}}, a_q};
    sel    = '0;
    case (opv_q[2:0])
      3'b001, 3'b010: sel = pa_q;
      3'b011:         sel = p2a_q;
      3'b100:         sel = n2a_q;
      3'b101, 3'b110: sel = na_q;
      default:        sel = '0;
    endcase
    addend     = sel << {cnt_q, 1'b0};
    // Uniform remaining multiplier bits contribute only zero digits from here on.
    early      = EARLY_TERM && ((&opv_q) || !(|opv_q));
    last_digit = (cnt_q == CW'(ND - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      opv_q   <= '0;
      pa_q    <= '0;
      p2a_q   <= '0;
      na_q    <= '0;
      n2a_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      type_q  <= '0;
      tag_q   <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= ext_a;
            opv_q   <= {ext_b, 1'b0};
            type_q  <= mul_type;
            tag_q   <= in_tag;
            state_q <= StPre;
          end
        end
        StPre: begin
          pa_q    <= a_wide;
          p2a_q   <= a_wide << 1;
          na_q    <= -a_wide;
          n2a_q   <= -(a_wide << 1);
          prod_q  <= '0;
          cnt_q   <= '0;
          state_q <= StCalc;
        end
        StCalc: begin
          if (early) begin
            state_q <= StDone;
          end else begin
            prod_q <= prod_q + addend;
            opv_q  <= {{2{opv_q[VW-1]}}, opv_q[VW-1:2]};
            cnt_q  <= cnt_q + CW'(1);
            if (last_digit) state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Guard bits only absorb the most-negative squared case; they never reach the result.
  logic unused_guard;
  assign unused_guard = ^prod_q[PW-1:2*XLEN];

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_tag   = tag_q;
  assign out_data  = (type_q == 2'b00) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_booth_r4_mul_pipe.sv
// Scoreboard bench for booth_r4_mul_pipe: three instances (32-bit early-exit, 32-bit full,
// 64-bit full) checked against a plain-arithmetic reference product.
module tb_booth_r4_mul_pipe;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   rnd_on = 1'b0;

  logic        in_valid  [3];
  logic        out_ready [3];
  logic        flush     [3];
  logic [1:0]  mtype     [3];
  logic [63:0] a         [3];
  logic [63:0] b         [3];
  logic [3:0]  tag       [3];

  logic        in_ready  [3];
  logic        out_valid [3];
  logic        busy      [3];
  logic [63:0] odata     [3];
  logic [3:0]  otag      [3];

  exp_t q [3][$];
  int   xw [3] = '{32, 32, 64};

  logic        e_ir, e_ov, e_bz, f_ir, f_ov, f_bz, w_ir, w_ov, w_bz;
  logic [31:0] e_od, f_od;
  logic [63:0] w_od;
  logic [3:0]  e_ot, f_ot, w_ot;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_r4_mul_pipe #(.XLEN(32), .TAG_W(4), .EARLY_TERM(1'b1)) u_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(e_ir), .mul_type(mtype[0]),
    .op_a(a[0][31:0]), .op_b(b[0][31:0]), .in_tag(tag[0]), .flush(flush[0]),
    .out_valid(e_ov), .out_ready(out_ready[0]), .out_data(e_od), .out_tag(e_ot), .busy(e_bz)
  );
  booth_r4_mul_pipe #(.XLEN(32), .TAG_W(4), .EARLY_TERM(1'b0)) u_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(f_ir), .mul_type(mtype[1]),
    .op_a(a[1][31:0]), .op_b(b[1][31:0]), .in_tag(tag[1]), .flush(flush[1]),
    .out_valid(f_ov), .out_ready(out_ready[1]), .out_data(f_od), .out_tag(f_ot), .busy(f_bz)
  );
  booth_r4_mul_pipe #(.XLEN(64), .TAG_W(4), .EARLY_TERM(1'b0)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(w_ir), .mul_type(mtype[2]),
    .op_a(a[2]), .op_b(b[2]), .in_tag(tag[2]), .flush(flush[2]),
    .out_valid(w_ov), .out_ready(out_ready[2]), .out_data(w_od), .out_tag(w_ot), .busy(w_bz)
  );

  assign in_ready[0] = e_ir;
  assign in_ready[1] = f_ir;
  assign in_ready[2] = w_ir;
  assign out_valid[0] = e_ov;
  assign out_valid[1] = f_ov;
  assign out_valid[2] = w_ov;
  assign busy[0] = e_bz;
  assign busy[1] = f_bz;
  assign busy[2] = w_bz;
  assign odata[0] = 64'(e_od);
  assign odata[1] = 64'(f_od);
  assign odata[2] = w_od;
  assign otag[0] = e_ot;
  assign otag[1] = f_ot;
  assign otag[2] = w_ot;

  // Reference: exact signed/unsigned product of the extended operands, then pick a half.
  function automatic logic [63:0] ref_mul(input int w, input logic [1:0] t,
                                          input logic [63:0] x, input logic [63:0] y);
    logic signed [129:0] one, span, mask, ea, eb, p;
    one  = 1;
    span = one << w;
    mask = span - one;
    ea   = $signed(130'(x)) & mask;
    eb   = $signed(130'(y)) & mask;
    if (t != 2'b11 && x[w-1]) ea = ea - span;
    if (!t[1] && y[w-1]) eb = eb - span;
    p = ea * eb;
    if (t != 2'b00) p = p >>> w;
    return 64'(p & mask);
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] m, r;
    m = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = 64'd0;
      1: r = 64'hFFFF_FFFF_FFFF_FFFF;
      2: r = 64'd1 << (w - 1);
      3: r = (64'd1 << (w - 1)) - 64'd1;
      default: ;
    endcase
    return r & m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    total++;
    if (act < 0 || act > lim) begin
      bad++;
      $display("FAIL %s: got latency %0d want 0..%0d", nm, act, lim);
    end
  endtask

  task automatic issue(input int k, input logic [1:0] t, input logic [63:0] x,
                       input logic [63:0] y, input logic [3:0] tg, input bit push,
                       input logic [63:0] ev, output int acc);
    int n;
    n = 0;
    acc = -1;
    mtype[k] = t;
    a[k] = x;
    b[k] = y;
    tag[k] = tg;
    in_valid[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready[k] && !flush[k] && rst_n) break;
      n++;
      if (n > 400) begin
        total++;
        bad++;
        $display("FAIL accept_timeout dut%0d: got no accept want accept in 400 cycles", k);
        in_valid[k] = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (push) q[k].push_back(exp_t'{data: ev, tag: tg});
    #1;
    in_valid[k] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_valid(input int k, input int acc, output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      if (out_valid[k]) begin
        lat = cyc - acc;
        return;
      end
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL valid_timeout dut%0d: got no out_valid want out_valid in 300 cycles", k);
  endtask

  task automatic rand_run(input int k, input int nops);
    int acc;
    logic [1:0]  t;
    logic [63:0] x, y;
    logic [3:0]  tg;
    for (int i = 0; i < nops; i++) begin
      t  = 2'(i % 4);
      x  = rnd_op(xw[k]);
      y  = rnd_op(xw[k]);
      tg = 4'($urandom);
      issue(k, t, x, y, tg, 1'b1, ref_mul(xw[k], t, x, y), acc);
    end
    for (int n = 0; n < 2000 && q[k].size() != 0; n++) @(posedge clk);
    chk($sformatf("drain_dut%0d", k), 64'(q[k].size()), 64'd0);
  endtask

  // Monitor: every retire pops the oldest expectation of that instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst_n && out_valid[k] && out_ready[k] && !flush[k]) begin
          total++;
          if (q[k].size() == 0) begin
            bad++;
            $display("FAIL unexpected_result dut%0d: got data=%h tag=%h want no result",
                     k, odata[k], otag[k]);
          end else begin
            e = q[k].pop_front();
            if (odata[k] !== e.data || otag[k] !== e.tag) begin
              bad++;
              $display("FAIL result dut%0d: got data=%h tag=%h want data=%h tag=%h",
                       k, odata[k], otag[k], e.data, e.tag);
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) begin
        for (int k = 0; k < 3; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, seen;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
      flush[k] = 1'b0;
      mtype[k] = 2'b00;
      a[k] = '0;
      b[k] = '0;
      tag[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready%0d", k), 64'(in_ready[k]), 64'd1);
      chk($sformatf("rst_out_valid%0d", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("rst_out_data%0d", k), odata[k], 64'd0);
      chk($sformatf("rst_out_tag%0d", k), 64'(otag[k]), 64'd0);
      chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
    end

    // Full-length run without early exit.
    issue(1, 2'b00, 64'd7, 64'hFFFF_FFFD, 4'h5, 1'b1, 64'hFFFF_FFEB, acc);
    wait_valid(1, acc, lat);
    chk("lat_full_7xm3", 64'(lat), 64'd18);

    issue(0, 2'b01, 64'h8000_0000, 64'h8000_0000, 4'h1, 1'b1, 64'h4000_0000, acc);
    issue(0, 2'b00, 64'h8000_0000, 64'h8000_0000, 4'h2, 1'b1, 64'h0, acc);
    issue(0, 2'b11, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'h3, 1'b1, 64'hFFFF_FFFE, acc);
    issue(0, 2'b10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'h4, 1'b1, 64'hFFFF_FFFF, acc);
    issue(2, 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h6, 1'b1,
          64'h4000_0000_0000_0000, acc);

    issue(0, 2'b00, 64'd5, 64'd3, 4'h7, 1'b1, 64'd15, acc);
    wait_valid(0, acc, lat);
    chk_le("lat_early_5x3", lat, 5);
    issue(0, 2'b00, 64'h1234_5678, 64'd0, 4'h8, 1'b1, 64'd0, acc);
    wait_valid(0, acc, lat);
    chk_le("lat_early_xx0", lat, 3);
    // Unsigned multiplier with bit 31 set never looks uniform, so no early exit.
    issue(0, 2'b11, 64'h1234, 64'h8000_0001, 4'hB, 1'b1, 64'h91A, acc);
    wait_valid(0, acc, lat);
    chk("lat_early_noexit", 64'(lat), 64'd18);

    // Back-pressure: result must sit still while out_ready is low.
    issue(0, 2'b00, 64'h1234, 64'h10, 4'h9, 1'b1, 64'h12340, acc);
    out_ready[0] = 1'b0;
    wait_valid(0, acc, lat);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 64'(out_valid[0]), 64'd1);
      chk("hold_data", odata[0], 64'h12340);
      chk("hold_tag", 64'(otag[0]), 64'h9);
      chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("retire_in_ready", 64'(in_ready[0]), 64'd1);
    chk("retire_out_valid", 64'(out_valid[0]), 64'd0);
    chk("retire_busy", 64'(busy[0]), 64'd0);

    // Flush while cnt==5 in CALC.
    issue(0, 2'b11, 64'h1234, 64'h8000_0001, 4'hC, 1'b0, 64'd0, acc);
    repeat (6) @(posedge clk);
    #1;
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    chk("flush_in_ready", 64'(in_ready[0]), 64'd1);
    chk("flush_busy", 64'(busy[0]), 64'd0);
    chk("flush_out_valid", 64'(out_valid[0]), 64'd0);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);
    issue(0, 2'b00, 64'd2, 64'd2, 4'hD, 1'b1, 64'd4, acc);
    wait_valid(0, acc, lat);

    // Asynchronous reset in the middle of CALC.
    issue(0, 2'b11, 64'h1234, 64'h8000_0001, 4'hA, 1'b0, 64'd0, acc);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready[0]), 64'd1);
    chk("arst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("arst_out_data", odata[0], 64'd0);
    chk("arst_out_tag", 64'(otag[0]), 64'd0);
    chk("arst_busy", 64'(busy[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rnd_on = 1'b1;
    fork
      rand_run(0, 800);
      rand_run(1, 800);
      rand_run(2, 800);
    join
    rnd_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
